// File: rtl/seq_pkg.sv
// Shared types and constants for the segment sequencer: state encoding,
// abort filler word, CSR map and counter helpers.
package seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CSR_AW = 2;
  localparam int unsigned WCNT_W = 9;

  localparam logic [DATA_W-1:0] FILLER_WORD = 32'hDEAD_BEEF;

  localparam logic [CSR_AW-1:0] CSR_CTRL = 2'd0;
  localparam logic [CSR_AW-1:0] CSR_PKT  = 2'd1;
  localparam logic [CSR_AW-1:0] CSR_ERR  = 2'd2;
  localparam logic [CSR_AW-1:0] CSR_TO   = 2'd3;

  typedef enum logic [2:0] {
    ST_SEG0  = 3'd0,
    ST_SEG1  = 3'd1,
    ST_SEG2  = 3'd2,
    ST_ABORT = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // Saturating increment for the 32-bit status counters
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == '1) ? v : v + DATA_W'(1);
  endfunction

endpackage

// File: rtl/seq_csr.sv
// Control/status registers: enable bit plus packet, error and timeout
// counters (saturating, cleared by any write to their address).
module seq_csr
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_inc_i,
  input  logic              err_inc_i,
  input  logic              to_inc_i,
  output logic              enable_o,
  input  logic [CSR_AW-1:0] csr_address_i,
  input  logic              csr_read_i,
  output logic [DATA_W-1:0] csr_readdata_o,
  input  logic              csr_write_i,
  input  logic [DATA_W-1:0] csr_writedata_i
);

  logic              enable_q, enable_d;
  logic [DATA_W-1:0] pkt_q, pkt_d;
  logic [DATA_W-1:0] err_q, err_d;
  logic [DATA_W-1:0] to_q, to_d;
  logic              unused_wdata;

  assign unused_wdata = ^csr_writedata_i[DATA_W-1:1];
  assign enable_o     = enable_q;

  // Clear beats increment when both land in the same cycle
  always_comb begin
    enable_d = enable_q;
    pkt_d    = pkt_inc_i ? sat_inc(pkt_q) : pkt_q;
    err_d    = err_inc_i ? sat_inc(err_q) : err_q;
    to_d     = to_inc_i  ? sat_inc(to_q)  : to_q;
    if (csr_write_i) begin
      case (csr_address_i)
        CSR_CTRL: enable_d = csr_writedata_i[0];
        CSR_PKT:  pkt_d    = '0;
        CSR_ERR:  err_d    = '0;
        CSR_TO:   to_d     = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b1;
      pkt_q    <= '0;
      err_q    <= '0;
      to_q     <= '0;
    end else begin
      enable_q <= enable_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    csr_readdata_o = '0;
    if (csr_read_i) begin
      case (csr_address_i)
        CSR_CTRL: csr_readdata_o = {{(DATA_W-1){1'b0}}, enable_q};
        CSR_PKT:  csr_readdata_o = pkt_q;
        CSR_ERR:  csr_readdata_o = err_q;
        CSR_TO:   csr_readdata_o = to_q;
      endcase
    end
  end

endmodule

// File: rtl/st_seg_sequencer.sv
// Stitches three Avalon-ST segments (header, channel data, result) into one
// UDP-bound packet, with length checking, idle timeout abort and drain.
module st_seg_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned LEN0    = 3,
  parameter int unsigned LEN1    = 160,
  parameter int unsigned LEN2    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] seg0_data,
  input  logic              seg0_valid,
  output logic              seg0_ready,
  input  logic              seg0_startofpacket,
  input  logic              seg0_endofpacket,
  input  logic [DATA_W-1:0] seg1_data,
  input  logic              seg1_valid,
  output logic              seg1_ready,
  input  logic              seg1_startofpacket,
  input  logic              seg1_endofpacket,
  input  logic [DATA_W-1:0] seg2_data,
  input  logic              seg2_valid,
  output logic              seg2_ready,
  input  logic              seg2_startofpacket,
  input  logic              seg2_endofpacket,
  output logic [DATA_W-1:0] to_udp_data,
  output logic              to_udp_valid,
  input  logic              to_udp_ready,
  output logic              to_udp_startofpacket,
  output logic              to_udp_endofpacket,
  output logic [1:0]        to_udp_empty,
  input  logic [CSR_AW-1:0] csr_address,
  input  logic              csr_read,
  output logic [DATA_W-1:0] csr_readdata,
  input  logic              csr_write,
  input  logic [DATA_W-1:0] csr_writedata
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic                open_q, open_d;
  logic [WCNT_W-1:0]   word_q, word_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                enable;
  logic                pkt_inc, err_inc, to_inc;
  logic                beat, in_seg, seg_eop;
  int unsigned         seg_len;
  logic                unused_sop;

  assign unused_sop = seg1_startofpacket ^ seg2_startofpacket;

  seq_csr u_csr (
    .clk             (clk),
    .rst             (rst),
    .pkt_inc_i       (pkt_inc),
    .err_inc_i       (err_inc),
    .to_inc_i        (to_inc),
    .enable_o        (enable),
    .csr_address_i   (csr_address),
    .csr_read_i      (csr_read),
    .csr_readdata_o  (csr_readdata),
    .csr_write_i     (csr_write),
    .csr_writedata_i (csr_writedata)
  );

  always_comb begin
    seg0_ready           = 1'b0;
    seg1_ready           = 1'b0;
    seg2_ready           = 1'b0;
    to_udp_data          = '0;
    to_udp_valid         = 1'b0;
    to_udp_startofpacket = 1'b0;
    to_udp_endofpacket   = 1'b0;
    to_udp_empty         = 2'b00;
    state_d              = state_q;
    open_d               = open_q;
    word_d               = word_q;
    idle_d               = idle_q;
    pkt_inc              = 1'b0;
    err_inc              = 1'b0;
    to_inc               = 1'b0;
    in_seg               = 1'b0;
    seg_eop              = 1'b0;
    seg_len              = 0;

    case (state_q)
      ST_SEG0: begin
        in_seg      = 1'b1;
        to_udp_data = seg0_data;
        seg_eop     = seg0_endofpacket;
        seg_len     = LEN0;
        if (open_q) begin
          to_udp_valid = seg0_valid;
          seg0_ready   = to_udp_ready;
        end else if (enable) begin
          // A header word without sop cannot start a packet: swallow it
          if (seg0_valid && !seg0_startofpacket) begin
            seg0_ready = 1'b1;
            err_inc    = 1'b1;
          end else begin
            to_udp_valid         = seg0_valid;
            seg0_ready           = to_udp_ready;
            to_udp_startofpacket = seg0_valid;
          end
        end
      end
      ST_SEG1: begin
        in_seg       = 1'b1;
        to_udp_data  = seg1_data;
        to_udp_valid = seg1_valid;
        seg1_ready   = to_udp_ready;
        seg_eop      = seg1_endofpacket;
        seg_len      = LEN1;
      end
      ST_SEG2: begin
        in_seg             = 1'b1;
        to_udp_data        = seg2_data;
        to_udp_valid       = seg2_valid;
        seg2_ready         = to_udp_ready;
        to_udp_endofpacket = seg2_valid && seg2_endofpacket;
        seg_eop            = seg2_endofpacket;
        seg_len            = LEN2;
      end
      ST_ABORT: begin
        to_udp_valid       = 1'b1;
        to_udp_data        = FILLER_WORD;
        to_udp_endofpacket = 1'b1;
        if (to_udp_ready) begin
          state_d = ST_DRAIN;
          word_d  = '0;
          idle_d  = '0;
        end
      end
      ST_DRAIN: begin
        seg1_ready = 1'b1;
        seg2_ready = 1'b1;
        if (seg2_valid && seg2_endofpacket) begin
          state_d = ST_SEG0;
          open_d  = 1'b0;
          word_d  = '0;
          idle_d  = '0;
        end
      end
      default: begin
        state_d = ST_SEG0;
        open_d  = 1'b0;
        word_d  = '0;
        idle_d  = '0;
      end
    endcase

    beat = in_seg && to_udp_valid && to_udp_ready;

    // Word accounting, segment advance and idle timeout for forwarding states
    if (beat) begin
      open_d = 1'b1;
      idle_d = '0;
      word_d = (word_q == '1) ? word_q : word_q + WCNT_W'(1);
      if (seg_eop) begin
        if ((32'(word_q) + 32'd1) != seg_len) err_inc = 1'b1;
        word_d = '0;
        case (state_q)
          ST_SEG0: state_d = ST_SEG1;
          ST_SEG1: state_d = ST_SEG2;
          default: begin
            state_d = ST_SEG0;
            open_d  = 1'b0;
            pkt_inc = 1'b1;
          end
        endcase
      end
    end else if (in_seg && open_q) begin
      if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
        state_d = ST_ABORT;
        to_inc  = 1'b1;
        idle_d  = '0;
        word_d  = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end

    // Hold the streaming interface quiet while reset is applied
    if (rst) begin
      seg0_ready           = 1'b0;
      seg1_ready           = 1'b0;
      seg2_ready           = 1'b0;
      to_udp_valid         = 1'b0;
      to_udp_startofpacket = 1'b0;
      to_udp_endofpacket   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SEG0;
      open_q  <= 1'b0;
      word_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      open_q  <= open_d;
      word_q  <= word_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_st_seg_sequencer.sv
// Scoreboard bench for st_seg_sequencer: forwarded words are queued when
// driven and compared as they leave on the to_udp port.
module tb_st_seg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seg0_data, seg1_data, seg2_data;
  logic        seg0_valid, seg1_valid, seg2_valid;
  logic        seg0_ready, seg1_ready, seg2_ready;
  logic        seg0_startofpacket, seg1_startofpacket, seg2_startofpacket;
  logic        seg0_endofpacket, seg1_endofpacket, seg2_endofpacket;
  logic [31:0] to_udp_data;
  logic        to_udp_valid, to_udp_ready;
  logic        to_udp_startofpacket, to_udp_endofpacket;
  logic [1:0]  to_udp_empty;
  logic [1:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_readdata, csr_writedata;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int pkt_id = 0;
  logic [33:0] expq[$];

  always #5 clk = ~clk;

  st_seg_sequencer dut (
    .clk(clk), .rst(rst),
    .seg0_data(seg0_data), .seg0_valid(seg0_valid), .seg0_ready(seg0_ready),
    .seg0_startofpacket(seg0_startofpacket), .seg0_endofpacket(seg0_endofpacket),
    .seg1_data(seg1_data), .seg1_valid(seg1_valid), .seg1_ready(seg1_ready),
    .seg1_startofpacket(seg1_startofpacket), .seg1_endofpacket(seg1_endofpacket),
    .seg2_data(seg2_data), .seg2_valid(seg2_valid), .seg2_ready(seg2_ready),
    .seg2_startofpacket(seg2_startofpacket), .seg2_endofpacket(seg2_endofpacket),
    .to_udp_data(to_udp_data), .to_udp_valid(to_udp_valid), .to_udp_ready(to_udp_ready),
    .to_udp_startofpacket(to_udp_startofpacket), .to_udp_endofpacket(to_udp_endofpacket),
    .to_udp_empty(to_udp_empty),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every accepted beat must match the head of the queue
  always @(negedge clk) begin : mon
    logic [33:0] e;
    if (!rst && to_udp_valid && to_udp_ready) begin
      beats++;
      chk("exp_avail", 64'(expq.size() != 0), 64'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("data", 64'(to_udp_data), 64'(e[33:2]));
        chk("sop", 64'(to_udp_startofpacket), 64'(e[1]));
        chk("eop", 64'(to_udp_endofpacket), 64'(e[0]));
      end
      chk("empty", 64'(to_udp_empty), 64'd0);
    end
  end

  task automatic set_seg(input int s, input logic v, input logic [31:0] d,
                         input logic sop, input logic eop);
    case (s)
      0: begin seg0_valid = v; seg0_data = d; seg0_startofpacket = sop; seg0_endofpacket = eop; end
      1: begin seg1_valid = v; seg1_data = d; seg1_startofpacket = sop; seg1_endofpacket = eop; end
      default: begin seg2_valid = v; seg2_data = d; seg2_startofpacket = sop; seg2_endofpacket = eop; end
    endcase
  endtask

  function automatic logic rdy(input int s);
    case (s)
      0: return seg0_ready;
      1: return seg1_ready;
      default: return seg2_ready;
    endcase
  endfunction

  // Drive n words on segment s; eop on word eop_at (-1: none)
  task automatic send_seg(input int s, input int n, input int eop_at, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      int k;
      d = {8'(s), 8'(pkt_id), 16'(i)};
      set_seg(s, 1'b1, d, i == 0, i == eop_at);
      if (expect_out) expq.push_back({d, (s == 0 && i == 0), (s == 2 && i == eop_at)});
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!rdy(s) && k < 3000);
      if (!rdy(s)) chk("handshake_timeout", 64'(k), 64'd0);
      @(posedge clk); #1;
    end
    set_seg(s, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic send_pkt(input int n1);
    send_seg(0, 3, 2, 1'b1);
    send_seg(1, n1, n1 - 1, 1'b1);
    send_seg(2, 4, 3, 1'b1);
    pkt_id++;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] v);
    csr_address = a; csr_writedata = v; csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
  endtask

  task automatic chk_csr(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    csr_address = a; csr_read = 1'b1;
    #1 chk(tag, 64'(csr_readdata), 64'(exp));
    csr_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input int limit);
    int k;
    k = 0;
    while (expq.size() != 0 && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    chk("queue_drained", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit bp_done;
    rst = 1'b1; to_udp_ready = 1'b1;
    set_seg(0, 1'b0, 32'd0, 1'b0, 1'b0);
    set_seg(1, 1'b0, 32'd0, 1'b0, 1'b0);
    set_seg(2, 1'b0, 32'd0, 1'b0, 1'b0);
    csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(to_udp_valid), 64'd0);
    chk("rst_seg0_ready", 64'(seg0_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk_csr("rst_enable", 2'd0, 32'd1);
    chk_csr("rst_pkt", 2'd1, 32'd0);
    chk_csr("rst_err", 2'd2, 32'd0);
    chk_csr("rst_to", 2'd3, 32'd0);

    // Nominal packet, no backpressure
    beats = 0;
    send_pkt(160);
    wait_empty(50);
    chk("a_beats", 64'(beats), 64'd167);
    chk_csr("a_pkt", 2'd1, 32'd1);
    chk_csr("a_err", 2'd2, 32'd0);
    @(negedge clk);
    csr_address = 2'd1;
    #1 chk("rd_gated", 64'(csr_readdata), 64'd0);
    @(posedge clk); #1;

    // Random backpressure
    beats = 0; bp_done = 1'b0;
    fork
      begin send_pkt(160); bp_done = 1'b1; end
      begin
        while (!bp_done) begin
          @(posedge clk); #1 to_udp_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    to_udp_ready = 1'b1;
    wait_empty(50);
    chk("b_beats", 64'(beats), 64'd167);
    chk_csr("b_pkt", 2'd1, 32'd2);

    // Short channel segment
    beats = 0;
    send_pkt(159);
    wait_empty(50);
    chk("c_beats", 64'(beats), 64'd166);
    chk_csr("c_err", 2'd2, 32'd1);
    chk_csr("c_pkt", 2'd1, 32'd3);

    // Counter clears, then header word without sop while idle
    csr_wr(2'd1, 32'h1234);
    csr_wr(2'd2, 32'hFFFF_FFFF);
    chk_csr("clr_pkt", 2'd1, 32'd0);
    chk_csr("clr_err", 2'd2, 32'd0);
    set_seg(0, 1'b1, 32'hABCD_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("nosop_ready", 64'(seg0_ready), 64'd1);
    chk("nosop_valid", 64'(to_udp_valid), 64'd0);
    @(posedge clk); #1;
    set_seg(0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk_csr("nosop_err", 2'd2, 32'd1);

    // Timeout on silent result segment, then drain and recover
    send_seg(0, 3, 2, 1'b1);
    send_seg(1, 160, 159, 1'b1);
    pkt_id++;
    expq.push_back({32'hDEAD_BEEF, 1'b0, 1'b1});
    repeat (1000) @(posedge clk);
    #1 chk("abort_not_early", 64'(expq.size()), 64'd1);
    wait_empty(100);
    chk_csr("to_cnt", 2'd3, 32'd1);
    send_seg(2, 4, 3, 1'b0);
    chk_csr("drain_pkt", 2'd1, 32'd0);
    send_pkt(160);
    wait_empty(50);
    chk_csr("after_drain_pkt", 2'd1, 32'd1);
    chk_csr("after_drain_err", 2'd2, 32'd1);

    // Disable mid-packet: current packet completes, next is held off
    send_seg(0, 3, 2, 1'b1);
    csr_wr(2'd0, 32'd0);
    send_seg(1, 160, 159, 1'b1);
    send_seg(2, 4, 3, 1'b1);
    pkt_id++;
    wait_empty(50);
    chk_csr("dis_pkt", 2'd1, 32'd2);
    chk_csr("dis_enable", 2'd0, 32'd0);
    set_seg(0, 1'b1, 32'h5555_0000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dis_seg0_ready", 64'(seg0_ready), 64'd0);
      chk("dis_valid", 64'(to_udp_valid), 64'd0);
      @(posedge clk); #1;
    end
    set_seg(0, 1'b0, 32'd0, 1'b0, 1'b0);
    csr_wr(2'd0, 32'd1);
    send_pkt(160);
    wait_empty(50);
    chk_csr("en_pkt", 2'd1, 32'd3);

    // Reset in the middle of the channel segment
    send_seg(0, 3, 2, 1'b1);
    send_seg(1, 80, -1, 1'b1);
    pkt_id++;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_seg1_ready", 64'(seg1_ready), 64'd0);
    chk("mid_rst_valid", 64'(to_udp_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    set_seg(1, 1'b1, 32'h7777_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("no_resume_ready", 64'(seg1_ready), 64'd0);
    chk("no_resume_valid", 64'(to_udp_valid), 64'd0);
    @(posedge clk); #1;
    set_seg(1, 1'b0, 32'd0, 1'b0, 1'b0);
    chk_csr("post_rst_pkt", 2'd1, 32'd0);
    chk_csr("post_rst_err", 2'd2, 32'd0);
    chk_csr("post_rst_to", 2'd3, 32'd0);
    chk_csr("post_rst_en", 2'd0, 32'd1);
    beats = 0;
    send_pkt(160);
    wait_empty(50);
    chk("post_rst_beats", 64'(beats), 64'd167);
    chk_csr("post_rst_pkt2", 2'd1, 32'd1);
    chk_csr("post_rst_err2", 2'd2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/st_seg_sequencer.md
ST_SEG_SEQUENCER -- requirements
Module: st_seg_sequencer

Interface
REQ-001 Parameter LEN0, default 3, expected words in segment 0 (header).
REQ-002 Parameter LEN1, default 160, expected words in segment 1 (channel data).
REQ-003 Parameter LEN2, default 4, expected words in segment 2 (reconstruction result).
REQ-004 Parameter TIMEOUT, default 1024, idle cycles allowed inside an open packet.
REQ-005 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 segN_data  in  32, segN_valid  in  1, segN_ready  out  1, segN_startofpacket  in  1, segN_endofpacket  in  1; N=0,1,2; Avalon-ST sinks, readyLatency 0.
REQ-008 to_udp_data  out  32, to_udp_valid  out  1, to_udp_ready  in  1, to_udp_startofpacket  out  1, to_udp_endofpacket  out  1, to_udp_empty  out  2; Avalon-ST source, readyLatency 0.
REQ-009 csr_address  in  2, csr_read  in  1, csr_readdata  out  32, csr_write  in  1, csr_writedata  in  32; Avalon-MM slave, read latency 0.

Function
REQ-010 States: SEG0, SEG1, SEG2, ABORT, DRAIN; reset state SEG0 with packet_open=0.
REQ-011 Beat accepted = selected valid AND to_udp_ready; selected segment's data/valid/ready SHALL pass combinationally; unselected readies SHALL be 0; to_udp_empty SHALL be 0.
REQ-012 SEG0 with packet_open=0: seg0 beat with sop opens packet (word_cnt=1), forwarded with to_udp_startofpacket=1; seg0 beat without sop SHALL be consumed (seg0_ready=1, to_udp_valid=0) and err_cnt incremented.
REQ-013 to_udp_startofpacket SHALL be 1 only on first seg0 beat; to_udp_endofpacket only on seg2 beat carrying eop; segment sop/eop otherwise suppressed.
REQ-014 Accepted eop in SEGk SHALL move SEG0->SEG1, SEG1->SEG2, SEG2->SEG0 (packet_open=0, pkt_cnt+1); word_cnt cleared on each transition.
REQ-015 At accepted eop, if word_cnt+1 != LENk then err_cnt SHALL increment; sequencing continues unchanged.
REQ-016 word_cnt 9 bits, saturates at 511.
REQ-017 idle_cnt SHALL clear on every accepted beat and on entering a state, increment each cycle while packet_open=1 and no beat accepted; reaching TIMEOUT SHALL enter ABORT and increment to_cnt.
REQ-018 ABORT: to_udp_valid=1, data 32'hDEAD_BEEF, endofpacket=1, all seg readies 0; on to_udp_ready -> DRAIN.
REQ-019 DRAIN: seg1_ready=seg2_ready=1, seg0_ready=0, to_udp_valid=0; seg2 beat with eop -> SEG0, packet_open=0; pkt_cnt not incremented.
REQ-020 CSR addr0 bit0 = enable (reset 1); enable=0 SHALL block only opening new packets; an open packet completes.
REQ-021 CSR addr1 pkt_cnt, addr2 err_cnt, addr3 to_cnt; 32-bit, saturating; write any value to addr1..3 clears that counter; clear and increment in same cycle: clear wins.
REQ-022 csr_readdata SHALL be combinational from csr_address; 0 when csr_read=0.

Reset
REQ-023 rst SHALL force state SEG0, packet_open=0, word_cnt=idle_cnt=0, all counters 0, enable=1, to_udp_valid/sop/eop=0, all seg readies 0, mid-packet included; no partial packet resumed.

Structure
REQ-024 State encodings, DEAD_BEEF filler, CSR addresses in shared package seq_pkg.
REQ-025 Single sub-module seq_csr (register file and counters); FSM and mux in top.

Verification
REQ-026 3/160/4-word segments, ready always 1 -> 167 beats, sop on beat 1, eop on beat 167, pkt_cnt=1, err_cnt=0.
REQ-027 Random to_udp_ready backpressure 50% -> identical 167-word output, no lost/duplicated words.
REQ-028 seg1 with eop on word 159 -> packet of 166 words, err_cnt=1, pkt_cnt=1.
REQ-029 seg2 silent 1024 cycles after seg1 eop -> DEAD_BEEF with eop, to_cnt=1; later seg2 4 words drained, next packet normal.
REQ-030 rst asserted at channel word 80 -> outputs idle next cycle, counters 0; next full packet correct.
REQ-031 write addr0=0 then offer packet -> seg0_ready=0, no output; write addr0=1 -> packet forwarded.
